// File: rtl/dft_comp_seq.sv
// dft_comp_seq: computes one complex DFT/IDFT bin using a single shared complex multiply-accumulate
module dft_comp_seq #(
  parameter int WIDTH   = 24,
  parameter int FRAC    = 8,
  parameter int SAMPLES = 32,
  parameter int TW_FRAC = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       inverse,
  input  logic [$clog2(SAMPLES)-1:0] dft_idx,
  input  logic [SAMPLES*WIDTH-1:0]   src_real,
  input  logic [SAMPLES*WIDTH-1:0]   src_imag,
  output logic                       busy,
  output logic                       ready,
  output logic [WIDTH-1:0]           dft_real,
  output logic [WIDTH-1:0]           dft_imag,
  output logic                       sat
);
  localparam int KW  = $clog2(SAMPLES);
  localparam int TWW = TW_FRAC + 2;
  localparam int PW  = WIDTH + TW_FRAC + 3;
  localparam int AW  = PW + KW;
  localparam real PI = 3.14159265358979323846;
  localparam real TW_ONE = 2.0 ** TW_FRAC;
  localparam logic [KW-1:0] LAST = KW'(SAMPLES - 1);
  localparam logic signed [AW-1:0] HALF = AW'(1) <<< (TW_FRAC - 1);
  localparam logic signed [AW-1:0] MAXV = AW'({(WIDTH-1){1'b1}});
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, idx_q, tw_i;
  logic inv_q, pv, accept;
  logic signed [TWW-1:0] cos_t [SAMPLES];
  logic signed [TWW-1:0] sin_t [SAMPLES];
  logic signed [PW-1:0] xr, xi, c, s, m_re, m_im, p_re, p_im;
  logic signed [AW-1:0] acc_re, acc_im, f_re, f_im, r_re, r_im;
  logic [WIDTH-1:0] o_re, o_im;
  logic hi_re, lo_re, hi_im, lo_im;
  if (FRAC > WIDTH) begin : g_frac_unused
  end
  for (genvar t = 0; t < SAMPLES; t++) begin : g_rom
    localparam real C = $cos(2.0 * PI * t / SAMPLES) * TW_ONE;
    localparam real S = $sin(2.0 * PI * t / SAMPLES) * TW_ONE;
    assign cos_t[t] = TWW'(C >= 0.0 ? $rtoi(C + 0.5) : -$rtoi(0.5 - C));
    assign sin_t[t] = TWW'(S >= 0.0 ? $rtoi(S + 0.5) : -$rtoi(0.5 - S));
  end
  // twiddle index wraps modulo SAMPLES by truncation to KW bits
  assign tw_i   = idx_q * k;
  assign accept = start && (state == IDLE || state == DONE);
  assign busy   = state == RUN || state == FLUSH;
  assign ready  = state == DONE;
  always_comb begin
    xr = PW'(signed'(src_real[k*WIDTH +: WIDTH]));
    xi = PW'(signed'(src_imag[k*WIDTH +: WIDTH]));
    c = PW'(cos_t[tw_i]);
    s = PW'(inv_q ? -sin_t[tw_i] : sin_t[tw_i]);
    m_re = xr * c + s * xi;
    m_im = xi * c - s * xr;
    f_re = pv ? acc_re + AW'(p_re) : acc_re;
    f_im = pv ? acc_im + AW'(p_im) : acc_im;
    r_re = (f_re + HALF) >>> TW_FRAC;
    r_im = (f_im + HALF) >>> TW_FRAC;
    hi_re = r_re > MAXV;
    lo_re = r_re < MINV;
    hi_im = r_im > MAXV;
    lo_im = r_im < MINV;
    o_re = hi_re ? MAXV[WIDTH-1:0] : lo_re ? MINV[WIDTH-1:0] : r_re[WIDTH-1:0];
    o_im = hi_im ? MAXV[WIDTH-1:0] : lo_im ? MINV[WIDTH-1:0] : r_im[WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (state == RUN) state_n = k == LAST ? FLUSH : RUN;
    else if (state == FLUSH) state_n = DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= '0;
      idx_q <= '0;
      inv_q <= 1'b0;
      pv <= 1'b0;
      p_re <= '0;
      p_im <= '0;
      acc_re <= '0;
      acc_im <= '0;
      dft_real <= '0;
      dft_imag <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      k <= '0;
      idx_q <= dft_idx;
      inv_q <= inverse;
      pv <= 1'b0;
      acc_re <= '0;
      acc_im <= '0;
      sat <= 1'b0;
    end else if (state == RUN) begin
      p_re <= m_re;
      p_im <= m_im;
      acc_re <= f_re;
      acc_im <= f_im;
      pv <= 1'b1;
      k <= k + 1'b1;
    end else if (state == FLUSH) begin
      dft_real <= o_re;
      dft_imag <= o_im;
      sat <= hi_re | lo_re | hi_im | lo_im;
    end
  end
endmodule

// File: tb/tb_dft_comp_seq.sv
// tb_dft_comp_seq: directed and randomized checks of dft_comp_seq at 4 and 32 points against a floating-point DFT model
module tb_dft_comp_seq;
  localparam int W = 24;
  localparam real PI = 3.14159265358979323846;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  logic clk = 1'b0;
  logic reset, start, inverse, sel;
  logic [4:0] idx;
  int xr [32];
  int xi [32];
  logic [4*W-1:0] r4, i4;
  logic [32*W-1:0] r32, i32;
  logic busy4, ready4, sat4, busy32, ready32, sat32;
  logic [W-1:0] dr4, di4, dr32, di32;
  logic busy, ready, sat;
  logic [W-1:0] dr, di;
  logic s0, b0;
  logic [W-1:0] r0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  always_comb begin
    r4 = '0;
    i4 = '0;
    r32 = '0;
    i32 = '0;
    for (int k = 0; k < 4; k++) begin
      r4[k*W +: W] = W'(xr[k]);
      i4[k*W +: W] = W'(xi[k]);
    end
    for (int k = 0; k < 32; k++) begin
      r32[k*W +: W] = W'(xr[k]);
      i32[k*W +: W] = W'(xi[k]);
    end
  end
  assign busy  = sel ? busy32 : busy4;
  assign ready = sel ? ready32 : ready4;
  assign sat   = sel ? sat32 : sat4;
  assign dr    = sel ? dr32 : dr4;
  assign di    = sel ? di32 : di4;
  dft_comp_seq #(.WIDTH(W), .FRAC(8), .SAMPLES(4), .TW_FRAC(14)) dut4 (
    .clk(clk), .reset(reset), .start(start & ~sel), .inverse(inverse), .dft_idx(idx[1:0]),
    .src_real(r4), .src_imag(i4), .busy(busy4), .ready(ready4),
    .dft_real(dr4), .dft_imag(di4), .sat(sat4));
  dft_comp_seq #(.WIDTH(W), .FRAC(8), .SAMPLES(32), .TW_FRAC(14)) dut32 (
    .clk(clk), .reset(reset), .start(start & sel), .inverse(inverse), .dft_idx(idx),
    .src_real(r32), .src_imag(i32), .busy(busy32), .ready(ready32),
    .dft_real(dr32), .dft_imag(di32), .sat(sat32));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic longint rnd(input real v);
    return v >= 0.0 ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(0.5 - v));
  endfunction
  task automatic clamp(input longint acc, output logic [W-1:0] o, output logic h);
    longint v;
    v = (acc + 8192) >>> 14;
    h = v > MAXV || v < -MAXV - 1;
    o = W'(v > MAXV ? MAXV : v < -MAXV - 1 ? -MAXV - 1 : v);
  endtask
  // X[bi] = sum x[k] * W^(bi*k) with twiddles quantised to 2^-14, no 1/N scaling
  task automatic model(input int n, input int bi, input bit inv,
                       output logic [W-1:0] er, output logic [W-1:0] ei, output logic es);
    longint ar, ai, c, s;
    real a;
    logic hr, hm;
    ar = 0;
    ai = 0;
    for (int k = 0; k < n; k++) begin
      a = 2.0 * PI * real'((bi * k) % n) / real'(n);
      c = rnd($cos(a) * 16384.0);
      s = rnd($sin(a) * 16384.0);
      if (inv) s = -s;
      ar += longint'(xr[k]) * c + s * longint'(xi[k]);
      ai += longint'(xi[k]) * c - s * longint'(xr[k]);
    end
    clamp(ar, er, hr);
    clamp(ai, ei, hm);
    es = hr | hm;
  endtask
  task automatic run_bin(input int bi, input bit inv, input bit pulse, output int lat);
    @(negedge clk);
    idx = 5'(bi);
    inverse = inv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s0 = sat;
    r0 = dr;
    b0 = busy;
    idx = 5'($urandom);
    inverse = 1'($urandom);
    lat = 0;
    while (!ready && lat < 200) begin
      start = pulse && lat[0];
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
  endtask
  task automatic verify(input string tag, input int n, input int bi, input bit inv);
    logic [W-1:0] er, ei;
    logic es;
    model(n, bi, inv, er, ei, es);
    chk({tag, "_re"}, 64'(dr), 64'(er));
    chk({tag, "_im"}, 64'(di), 64'(ei));
    chk({tag, "_sat"}, 64'(sat), 64'(es));
  endtask
  initial begin
    int lat;
    real mag;
    logic [W-1:0] exp_r [4];
    logic [W-1:0] exp_i [4];
    exp_r = '{24'h000500, 24'h000000, 24'h000300, 24'h000000};
    exp_i = '{24'h000000, 24'hffff00, 24'h000000, 24'h000100};
    reset = 1'b1;
    start = 1'b0;
    inverse = 1'b0;
    idx = '0;
    sel = 1'b0;
    for (int k = 0; k < 32; k++) begin
      xr[k] = 0;
      xi[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_sat", 64'(sat), 64'(0));
    chk("rst_out", 64'({dr, di}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    xr[0] = 32'h200;
    xr[1] = 32'h100;
    xr[2] = 32'h200;
    xr[3] = 0;
    for (int b = 0; b < 4; b++) begin
      run_bin(b, 1'b0, 1'b0, lat);
      chk("fwd_lat", 64'(lat), 64'(5));
      chk("fwd_busy_e0", 64'(b0), 64'(1));
      chk("fwd_re", 64'(dr), 64'(exp_r[b]));
      chk("fwd_im", 64'(di), 64'(exp_i[b]));
      chk("fwd_sat", 64'(sat), 64'(0));
      chk("fwd_busy_done", 64'(busy), 64'(0));
    end
    run_bin(1, 1'b1, 1'b0, lat);
    chk("inv1", 64'({dr, di}), 64'({24'h000000, 24'h000100}));
    run_bin(3, 1'b1, 1'b0, lat);
    chk("inv3", 64'({dr, di}), 64'({24'h000000, 24'hffff00}));
    run_bin(1, 1'b0, 1'b1, lat);
    chk("pulse_lat", 64'(lat), 64'(5));
    chk("pulse_res", 64'({dr, di}), 64'({24'h000000, 24'hffff00}));
    for (int k = 0; k < 4; k++) xr[k] = 32'h7fffff;
    run_bin(0, 1'b0, 1'b0, lat);
    chk("sat_re", 64'(dr), 64'(24'h7fffff));
    chk("sat_flag", 64'(sat), 64'(1));
    xr[0] = 32'h200;
    xr[1] = 32'h100;
    xr[2] = 32'h200;
    xr[3] = 0;
    run_bin(0, 1'b0, 1'b0, lat);
    chk("sat_clr_e0", 64'(s0), 64'(0));
    chk("hold_e0", 64'(r0), 64'(24'h7fffff));
    chk("after_sat", 64'({dr, di, 23'd0, sat}), 64'({24'h000500, 24'h000000, 24'd0}));
    @(negedge clk);
    idx = 5'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", 64'({busy, ready, sat}), 64'(0));
    chk("mid_rst_out", 64'({dr, di}), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("mid_rst_noready", 64'(ready), 64'(0));
    run_bin(2, 1'b0, 1'b0, lat);
    chk("post_rst", 64'({dr, di}), 64'({24'h000300, 24'h000000}));
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        xr[k] = j >= 6 ? int'($urandom_range(0, 16777215)) - 8388608 : int'($urandom_range(0, 4095)) - 2048;
        xi[k] = j >= 6 ? int'($urandom_range(0, 16777215)) - 8388608 : int'($urandom_range(0, 4095)) - 2048;
      end
      begin
        int bi;
        bit inv;
        bi = int'($urandom_range(0, 3));
        inv = 1'($urandom_range(0, 1));
        run_bin(bi, inv, 1'($urandom), lat);
        verify("rnd4", 4, bi, inv);
      end
    end
    sel = 1'b1;
    for (int k = 0; k < 32; k++) begin
      xr[k] = (k % 16) < 8 ? 256 : -256;
      xi[k] = 0;
    end
    run_bin(0, 1'b0, 1'b0, lat);
    chk("sq_lat", 64'(lat), 64'(33));
    chk("sq_idx0", 64'({dr, di}), 64'(0));
    run_bin(2, 1'b0, 1'b0, lat);
    verify("sq_idx2", 32, 2, 1'b0);
    mag = $sqrt(real'(signed'(dr)) ** 2 + real'(signed'(di)) ** 2) / 256.0;
    chk("sq_mag", 64'(mag > 19.5 && mag < 21.5), 64'(1));
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 32; k++) begin
        xr[k] = j == 4 ? int'($urandom_range(0, 16777215)) - 8388608 : int'($urandom_range(0, 65535)) - 32768;
        xi[k] = j == 4 ? int'($urandom_range(0, 16777215)) - 8388608 : int'($urandom_range(0, 65535)) - 32768;
      end
      begin
        int bi;
        bit inv;
        bi = int'($urandom_range(0, 31));
        inv = 1'($urandom_range(0, 1));
        run_bin(bi, inv, 1'($urandom), lat);
        chk("rnd32_lat", 64'(lat), 64'(33));
        verify("rnd32", 32, bi, inv);
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
